spike_interval_decoder: RTL

SPIKE_INTERVAL_DECODER -- requirements
Module: spike_interval_decoder

---
 rtl/spike_interval_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/spike_interval_decoder.sv
// rtl/spike_interval_decoder.sv - measures clk-cycle intervals between synchronized spike rising edges
// Output is a one-deep valid/ready holding register with a sticky overrun flag.
module spike_interval_decoder #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic             enable,
  input  logic             clr_flags,
  input  logic             isi_ready,
  output logic [CNT_W-1:0] isi_value,
  output logic             isi_valid,
  output logic             timeout,
  output logic             overrun,
  output logic [7:0]       spike_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   evt;
  logic                   meas_fire;
  logic                   meas_drop;

  // evt is registered so it lands SYNC_STAGES+1 edges after the spike_in rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      evt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], spike_in};
      edge_q <= sync_q[SYNC_STAGES-1];
      evt    <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  always_comb begin
    meas_fire = enable && (state == MEASURE) && evt;
    meas_drop = meas_fire && isi_valid && !isi_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (evt) begin
              state <= MEASURE;
              cnt   <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (evt) begin
              cnt <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              // Saturated: forget the open interval so the next spike restarts it.
              timeout <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_value <= '0;
      isi_valid <= 1'b0;
    end else if (meas_fire && (!isi_valid || isi_ready)) begin
      isi_value <= cnt;
      isi_valid <= 1'b1;
    end else if (isi_valid && isi_ready) begin
      isi_valid <= 1'b0;
    end
  end

  // A drop in the same cycle as clr_flags must still leave the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (meas_drop) begin
      overrun <= 1'b1;
    end else if (clr_flags) begin
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_count <= 8'd0;
    end else if (evt && enable) begin
      spike_count <= spike_count + 8'd1;
    end
  end

endmodule
